trig_conditioner: RTL and testbench

- Parametrised, multi-channel successor to the single registered target-trigger input in the top level.
- Synchronises and glitch-filters N asynchronous trigger pins, then applies per-channel edge/level qualification, OR/AND combining, output pulse stretching and re-trigger holdoff.
- Counts triggers; drives trig_out/mcx_trig and the m3_trig input of trace_top.
- Sits in the fe_clk domain; configuration comes from the USB register block, already synchronised to fe_clk.

---
 rtl/trig_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_trig_conditioner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_conditioner.sv
// Multi-channel trigger conditioner: sync, glitch filter, edge/level qualify, combine, stretch, holdoff, count.
// Optional build macro TRIG_TIMESTAMP_EN adds a free-running cycle counter and per-trigger timestamp capture.
`timescale 1ns/1ps
module trig_conditioner #(
   parameter int pCHANNELS      = 4,
   parameter int pFILTER_WIDTH  = 4,
   parameter int pSTRETCH_WIDTH = 8,
   parameter int pHOLDOFF_WIDTH = 16,
   parameter int pCOUNT_WIDTH   = 16
) (
   input  logic                        fe_clk,
   input  logic                        fe_reset_n,
   input  logic [pCHANNELS-1:0]        I_trig_in,
   input  logic [pCHANNELS-1:0]        I_enable,
   input  logic [2*pCHANNELS-1:0]      I_edge_mode,
   input  logic                        I_combine_and,
   input  logic [pFILTER_WIDTH-1:0]    I_filter_len,
   input  logic [pSTRETCH_WIDTH-1:0]   I_stretch_len,
   input  logic [pHOLDOFF_WIDTH-1:0]   I_holdoff_len,
   input  logic                        I_arm,
   input  logic                        I_clear_count,
   output logic                        O_trig_out,
   output logic                        O_trig_pulse,
   output logic [pCHANNELS-1:0]        O_filtered,
   output logic                        O_holdoff_active,
   output logic [pCOUNT_WIDTH-1:0]     O_trig_count
`ifdef TRIG_TIMESTAMP_EN
   ,
   output logic [31:0]                 O_timestamp,
   output logic                        O_timestamp_valid
`endif
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] READY   = 2'd1;
   localparam logic [1:0] STRETCH = 2'd2;
   localparam logic [1:0] HOLDOFF = 2'd3;

   logic [pCHANNELS-1:0]      r_s1;
   logic [pCHANNELS-1:0]      r_s2;
   logic [pCHANNELS-1:0]      r_filt;
   logic [pCHANNELS-1:0]      r_filt_d;
   logic [pFILTER_WIDTH-1:0]  r_fcnt [pCHANNELS];

   logic [1:0]                r_state;
   logic [pSTRETCH_WIDTH-1:0] r_str;
   logic [pHOLDOFF_WIDTH-1:0] r_hold;
   logic                      r_pulse;
   logic [pCOUNT_WIDTH-1:0]   r_count;

   logic [pCHANNELS-1:0]      w_qual;
   logic                      w_event;
   logic                      w_fire;

   // Filter commits s2 only after it has disagreed with filt for N+1 straight cycles.
   always_ff @(posedge fe_clk) begin
      if (!fe_reset_n) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_filt   <= '0;
         r_filt_d <= '0;
         for (int c = 0; c < pCHANNELS; c++) r_fcnt[c] <= '0;
      end else begin
         r_s1     <= I_trig_in;
         r_s2     <= r_s1;
         r_filt_d <= r_filt;
         for (int c = 0; c < pCHANNELS; c++) begin
            if (r_s2[c] == r_filt[c]) begin
               r_fcnt[c] <= '0;
            end else if (r_fcnt[c] == I_filter_len) begin
               r_filt[c] <= r_s2[c];
               r_fcnt[c] <= '0;
            end else begin
               r_fcnt[c] <= r_fcnt[c] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_qual = '0;
      for (int c = 0; c < pCHANNELS; c++) begin
         case (I_edge_mode[2*c +: 2])
            2'b00:   w_qual[c] =  r_filt[c] & ~r_filt_d[c];
            2'b01:   w_qual[c] = ~r_filt[c] &  r_filt_d[c];
            2'b10:   w_qual[c] =  r_filt[c] ^  r_filt_d[c];
            default: w_qual[c] =  r_filt[c];
         endcase
      end
   end

   // AND mode treats disabled channels as don't-care but needs at least one enabled.
   assign w_event = I_combine_and ? ((&(w_qual | ~I_enable)) & (|I_enable))
                                  : (|(w_qual & I_enable));
   assign w_fire  = I_arm && (r_state == READY) && w_event;

   always_ff @(posedge fe_clk) begin
      if (!fe_reset_n) begin
         r_state <= IDLE;
         r_str   <= '0;
         r_hold  <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         if (!I_arm) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE:  r_state <= READY;
               READY: begin
                  if (w_event) begin
                     r_state <= STRETCH;
                     r_str   <= I_stretch_len;
                     r_hold  <= I_holdoff_len;
                     r_pulse <= 1'b1;
                  end
               end
               STRETCH: begin
                  if (r_str == '0) begin
                     r_state <= (r_hold == '0) ? READY : HOLDOFF;
                  end else begin
                     r_str <= r_str - 1'b1;
                  end
               end
               default: begin
                  // r_hold counts H..1, giving exactly H cycles in HOLDOFF.
                  if (r_hold <= 1) begin
                     r_state <= READY;
                  end else begin
                     r_hold <= r_hold - 1'b1;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge fe_clk) begin
      if (!fe_reset_n) begin
         r_count <= '0;
      end else if (I_clear_count) begin
         r_count <= '0;
      end else if (w_fire && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

`ifdef TRIG_TIMESTAMP_EN
   logic [31:0] r_free;
   logic [31:0] r_ts;
   logic        r_ts_valid;

   // Captured value is what r_free holds during the O_trig_pulse cycle.
   always_ff @(posedge fe_clk) begin
      if (!fe_reset_n) begin
         r_free     <= '0;
         r_ts       <= '0;
         r_ts_valid <= 1'b0;
      end else begin
         r_free <= r_free + 32'd1;
         if (w_fire) r_ts <= r_free + 32'd1;
         if (I_clear_count) begin
            r_ts_valid <= 1'b0;
         end else if (w_fire) begin
            r_ts_valid <= 1'b1;
         end
      end
   end

   assign O_timestamp       = r_ts;
   assign O_timestamp_valid = r_ts_valid;
`endif

   assign O_trig_out       = (r_state == STRETCH);
   assign O_holdoff_active = (r_state == HOLDOFF);
   assign O_trig_pulse     = r_pulse;
   assign O_filtered       = r_filt;
   assign O_trig_count     = r_count;

endmodule

// File: tb/tb_trig_conditioner.sv
// Directed bench for trig_conditioner; expected values are hand-computed cycle counts.
`timescale 1ns/1ps
module tb_trig_conditioner;
   localparam int CH = 4;
   localparam int CW = 8;

   logic            fe_clk = 1'b0;
   logic            fe_reset_n;
   logic [CH-1:0]   I_trig_in;
   logic [CH-1:0]   I_enable;
   logic [2*CH-1:0] I_edge_mode;
   logic            I_combine_and;
   logic [3:0]      I_filter_len;
   logic [7:0]      I_stretch_len;
   logic [15:0]     I_holdoff_len;
   logic            I_arm;
   logic            I_clear_count;
   logic            O_trig_out;
   logic            O_trig_pulse;
   logic [CH-1:0]   O_filtered;
   logic            O_holdoff_active;
   logic [CW-1:0]   O_trig_count;
`ifdef TRIG_TIMESTAMP_EN
   logic [31:0]     O_timestamp;
   logic            O_timestamp_valid;
   logic [31:0]     tb_cyc;
   always @(posedge fe_clk) begin
      if (!fe_reset_n) tb_cyc <= '0;
      else             tb_cyc <= tb_cyc + 32'd1;
   end
`endif

   always #5 fe_clk = ~fe_clk;

   trig_conditioner #(
      .pCHANNELS(CH), .pFILTER_WIDTH(4), .pSTRETCH_WIDTH(8),
      .pHOLDOFF_WIDTH(16), .pCOUNT_WIDTH(CW)
   ) dut (
      .fe_clk(fe_clk), .fe_reset_n(fe_reset_n), .I_trig_in(I_trig_in),
      .I_enable(I_enable), .I_edge_mode(I_edge_mode), .I_combine_and(I_combine_and),
      .I_filter_len(I_filter_len), .I_stretch_len(I_stretch_len),
      .I_holdoff_len(I_holdoff_len), .I_arm(I_arm), .I_clear_count(I_clear_count),
      .O_trig_out(O_trig_out), .O_trig_pulse(O_trig_pulse), .O_filtered(O_filtered),
      .O_holdoff_active(O_holdoff_active), .O_trig_count(O_trig_count)
`ifdef TRIG_TIMESTAMP_EN
      , .O_timestamp(O_timestamp), .O_timestamp_valid(O_timestamp_valid)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge fe_clk);
         #1;
      end
   endtask

   // first = edge index of first O_trig_out high, width = high cycles, np = pulses seen
   task automatic run(input int ncyc, output int first, output int width, output int np);
      first = -1; width = 0; np = 0;
      for (int i = 1; i <= ncyc; i++) begin
         tick(1);
         if (O_trig_out) begin
            if (first < 0) first = i;
            width++;
         end
         if (O_trig_pulse) np++;
      end
   endtask

   task automatic pulse_run(input int ch, input int len, input int ncyc,
                            output int first, output int width, output int np);
      first = -1; width = 0; np = 0;
      I_trig_in[ch] = 1'b1;
      for (int i = 1; i <= ncyc; i++) begin
         tick(1);
         if (i == len) I_trig_in[ch] = 1'b0;
         if (O_trig_out) begin
            if (first < 0) first = i;
            width++;
         end
         if (O_trig_pulse) np++;
      end
   endtask

   initial begin
      int first, width, np, hcnt, p1, p2;
      fe_reset_n = 1'b0; I_trig_in = 4'hF; I_enable = '0; I_edge_mode = '0;
      I_combine_and = 1'b0; I_filter_len = '0; I_stretch_len = '0;
      I_holdoff_len = '0; I_arm = 1'b0; I_clear_count = 1'b0;

      // Reset with pins high
      tick(3);
      chk("rst_trig_out", O_trig_out, 0);
      chk("rst_pulse", O_trig_pulse, 0);
      chk("rst_filtered", O_filtered, 0);
      chk("rst_holdoff", O_holdoff_active, 0);
      chk("rst_count", O_trig_count, 0);
      fe_reset_n = 1'b1; I_enable = 4'hF; I_edge_mode = 8'hFF;
      run(10, first, width, np);
      chk("unarmed_pulses", np, 0);
      chk("unarmed_count", O_trig_count, 0);
      chk("unarmed_filtered", O_filtered, 4'hF);
      I_trig_in = '0;
      tick(5);

      // Basic latency, ch0 rising, S=3
      I_enable = 4'b0001; I_edge_mode = 8'h00; I_stretch_len = 8'd3; I_arm = 1'b1;
      tick(2);
      I_trig_in[0] = 1'b1;
      run(20, first, width, np);
      chk("lat_first", first, 4);
      chk("lat_width", width, 4);
      chk("lat_pulses", np, 1);
      chk("lat_count", O_trig_count, 1);
      I_trig_in = '0;
      tick(5);

      // Glitch filter N=5 on ch1
      I_enable = 4'b0010; I_filter_len = 4'd5;
      pulse_run(1, 5, 30, first, width, np);
      chk("glitch5_pulses", np, 0);
      pulse_run(1, 6, 30, first, width, np);
      chk("glitch6_first", first, 9);
      chk("glitch6_pulses", np, 1);
      chk("glitch6_count", O_trig_count, 2);
      I_filter_len = '0;
      tick(5);

      // AND combine: ch0 level, ch2 rising
      I_enable = 4'b0101; I_edge_mode = 8'b00_00_00_11; I_combine_and = 1'b1;
      I_trig_in[2] = 1'b1;
      run(10, first, width, np);
      chk("and_ch0low_pulses", np, 0);
      I_trig_in[2] = 1'b0; tick(5);
      I_trig_in[0] = 1'b1; tick(5);
      I_trig_in[2] = 1'b1;
      run(10, first, width, np);
      chk("and_first", first, 4);
      chk("and_pulses", np, 1);
      chk("and_count", O_trig_count, 3);
      I_trig_in = '0; tick(5);

      // No enabled channels never triggers
      I_combine_and = 1'b0; I_enable = '0; I_edge_mode = 8'hFF; I_trig_in = 4'hF;
      run(10, first, width, np);
      chk("en0_or_pulses", np, 0);
      I_combine_and = 1'b1;
      run(10, first, width, np);
      chk("en0_and_pulses", np, 0);
      I_combine_and = 1'b0; I_trig_in = '0; tick(5);

      // Holdoff H=100, S=2, ch0 held high in level mode
      I_enable = 4'b0001; I_stretch_len = 8'd2; I_holdoff_len = 16'd100;
      I_trig_in[0] = 1'b1;
      np = 0; hcnt = 0; p1 = -1; p2 = -1;
      for (int i = 1; i <= 300; i++) begin
         tick(1);
         if (O_trig_pulse) begin
            np++;
            if (np == 1) p1 = i;
            if (np == 2) p2 = i;
         end
         if (O_holdoff_active && np == 1) hcnt++;
      end
      chk("hold_first", p1, 4);
      chk("hold_spacing", p2 - p1, 104);
      chk("hold_active_cycles", hcnt, 100);
      chk("hold_pulses", np, 3);
      chk("hold_count", O_trig_count, 6);

      // Saturation: S=0, H=0 retriggers every 2 cycles
      I_stretch_len = '0; I_holdoff_len = '0;
      for (int i = 0; i < 1200 && O_trig_count != 8'hFF; i++) tick(1);
      chk("sat_reach", O_trig_count, 8'hFF);
      run(20, first, width, np);
      chk("sat_pulses", np, 10);
      chk("sat_hold", O_trig_count, 8'hFF);
      for (int i = 0; i < 4 && !O_trig_pulse; i++) tick(1);
      chk("sat_pulse_seen", O_trig_pulse, 1);
      tick(1);
      I_clear_count = 1'b1;
      tick(1);
      I_clear_count = 1'b0;
      chk("clr_pulse_same", O_trig_pulse, 1);
      chk("clr_wins", O_trig_count, 0);
      tick(1);
      chk("clr_after", O_trig_count, 0);
      tick(1);
      chk("clr_recount", O_trig_count, 1);
      I_arm = 1'b0;
      tick(3);

      // Re-arm with level input high, S=200, then disarm mid-stretch
      I_stretch_len = 8'd200;
      I_arm = 1'b1;
      first = -1; np = 0;
      for (int i = 1; i <= 11; i++) begin
         tick(1);
         if (O_trig_out && first < 0) first = i;
         if (O_trig_pulse) begin
            np++;
`ifdef TRIG_TIMESTAMP_EN
            chk("ts_value", O_timestamp, tb_cyc);
            chk("ts_valid", O_timestamp_valid, 1);
`endif
         end
      end
      chk("rearm_first", first, 2);
      chk("rearm_pulses", np, 1);
      chk("stretch_at_10", O_trig_out, 1);
      I_arm = 1'b0;
      tick(1);
      chk("disarm_trig_out", O_trig_out, 0);
      chk("disarm_state", dut.r_state, 0);
      chk("disarm_holdoff", O_holdoff_active, 0);
      tick(5);
      chk("disarm_stays_low", O_trig_out, 0);
      chk("disarm_count", O_trig_count, 2);
      I_clear_count = 1'b1;
      tick(1);
      I_clear_count = 1'b0;
      chk("clear_alone", O_trig_count, 0);
`ifdef TRIG_TIMESTAMP_EN
      chk("ts_valid_cleared", O_timestamp_valid, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
